// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter that lends the shared 8-digit seven-segment display to
// one of NUM_REQ debug sources at a time. Each grant holds the display for
// HOLD_CYCLES cycles. The last accepted value stays shown while the arbiter idles.
module seg_display_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter logic [31:0] IDLE_VAL    = 32'h0
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  input  logic [NUM_REQ*32-1:0]      req_val_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  output logic [31:0]                val_out,
  output logic [$clog2(NUM_REQ)-1:0] owner_out,
  output logic                       busy_out
);

  localparam int unsigned     IdxW    = $clog2(NUM_REQ);
  localparam int unsigned     CntW    = $clog2(HOLD_CYCLES + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_CYCLES - 1);

  typedef enum logic {StIdle, StShow} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     val_q, val_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic            busy_q, busy_d;

  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic [31:0]     cand;

  // Round-robin search starting just after the previous winner, with wrap-around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_q) + k) % NUM_REQ;
      if (!win_found && req_valid_in[cand[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  // One-hot accept, only while idle; reset blocks any handshake in its cycle
  always_comb begin
    req_ready_out = '0;
    if (state_q == StIdle && win_found && !rst_in) begin
      req_ready_out[win_idx] = 1'b1;
    end
  end

  // Next-state: latch the winner in IDLE, count out the hold in SHOW
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          val_d   = req_val_in[32*win_idx +: 32];
          owner_d = win_idx;
          last_d  = win_idx;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StShow;
        end
      end
      StShow: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; requester 0 wins the first search
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      last_q  <= LastIdx;
      cnt_q   <= '0;
      val_q   <= IDLE_VAL;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  assign val_out   = val_q;
  assign owner_out = owner_q;
  assign busy_out  = busy_q;

endmodule
